// File: rtl/canny_ctrl_pkg.sv
// Shared types and helpers for the edge-detection pipeline control slice.
package canny_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } buf_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        FILL,
        RUN,
        TURN,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_pipeline_controller_if.sv
// Control bus between the scan sequencer and the stage datapaths.
interface scan_pipeline_controller_if #(
    parameter int NUM_STAGES = 4,
    parameter int COLS       = 640,
    parameter int ROWS       = 480
);
    import canny_ctrl_pkg::*;

    localparam int COL_W = cnt_w(COLS);
    localparam int ROW_W = cnt_w(ROWS);

    logic                    start;
    logic                    stall;
    logic [NUM_STAGES-1:0]   fill_done;
    logic [NUM_STAGES-1:0]   stage_en;
    logic [2*NUM_STAGES-1:0] buf_mode;
    logic                    write_enable;
    logic                    dir;
    logic [COL_W-1:0]        col;
    logic [ROW_W-1:0]        row;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, stall, fill_done,
        output stage_en, buf_mode, write_enable, dir, col, row, busy, done
    );

    modport slave (
        output start, stall, fill_done,
        input  stage_en, buf_mode, write_enable, dir, col, row, busy, done
    );

endinterface

// File: rtl/scan_position_counter.sv
// Serpentine column/row/direction tracker; column parks at the row end until the turn.
module scan_position_counter
    import canny_ctrl_pkg::*;
#(
    parameter  int COLS  = 640,
    parameter  int ROWS  = 480,
    localparam int COL_W = cnt_w(COLS),
    localparam int ROW_W = cnt_w(ROWS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_advance,
    input  logic             i_turn,
    input  logic             i_clear,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_dir,
    output logic             o_row_end,
    output logic             o_last_row
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_dir;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col <= '0;
            r_row <= '0;
            r_dir <= 1'b0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
            r_dir <= 1'b0;
        end else if (i_turn) begin
            r_dir <= ~r_dir;
            r_row <= r_row + 1'b1;
        end else if (i_advance && !o_row_end) begin
            r_col <= r_dir ? (r_col - 1'b1) : (r_col + 1'b1);
        end
    end

    assign o_row_end  = r_dir ? (r_col == '0) : (r_col == COL_W'(COLS - 1));
    assign o_last_row = (r_row == ROW_W'(ROWS - 1));
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_dir      = r_dir;

endmodule

// File: rtl/scan_pipeline_controller.sv
// Frame sequencer for the N-stage windowed pipeline: fill, serpentine scan,
// staggered row-turn waves and drain, with a global stall freeze.
module scan_pipeline_controller
    import canny_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int COLS       = 640,
    parameter int ROWS       = 480
) (
    input  logic                      clk,
    input  logic                      n_rst,
    scan_pipeline_controller_if.master ctrl_bus
);

    localparam int COL_W = cnt_w(COLS);
    localparam int ROW_W = cnt_w(ROWS);
    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] TURN_END = IDX_W'(NUM_STAGES);

    ctrl_state_t             r_state;
    ctrl_state_t             w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    w_stall;
    logic                    w_fill_hit;
    logic                    w_advance;
    logic                    w_turn;
    logic                    w_clear;
    logic [COL_W-1:0]        w_col;
    logic [ROW_W-1:0]        w_row;
    logic                    w_dir;
    logic                    w_row_end;
    logic                    w_last_row;
    logic [NUM_STAGES-1:0]   w_stage_en;
    logic [2*NUM_STAGES-1:0] w_buf_mode;
    logic                    w_we;
    buf_mode_t               w_old_mode;
    buf_mode_t               w_new_mode;
    buf_mode_t               w_mode;

    assign w_stall = ctrl_bus.stall && (r_state != IDLE);

    scan_position_counter #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_advance  (w_advance),
        .i_turn     (w_turn),
        .i_clear    (w_clear),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_dir      (w_dir),
        .o_row_end  (w_row_end),
        .o_last_row (w_last_row)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Only the fill_done bit of the stage currently priming matters.
    always_comb begin
        w_fill_hit = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_idx == IDX_W'(k)) w_fill_hit = ctrl_bus.fill_done[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_advance   = 1'b0;
        w_turn      = 1'b0;
        w_clear     = 1'b0;
        if (!w_stall) begin
            case (r_state)
                IDLE:  if (ctrl_bus.start) w_state_nxt = PREP;
                PREP: begin
                    w_state_nxt = FILL;
                    w_clear     = 1'b1;
                end
                FILL: begin
                    if (w_fill_hit) begin
                        if (r_idx == LAST_IDX) w_state_nxt = RUN;
                        else                   w_idx_nxt   = r_idx + 1'b1;
                    end
                end
                RUN: begin
                    w_advance = 1'b1;
                    if (w_row_end) w_state_nxt = w_last_row ? DRAIN : TURN;
                end
                TURN: begin
                    if (r_idx == TURN_END) begin
                        w_state_nxt = RUN;
                        w_turn      = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_idx == LAST_IDX) w_state_nxt = DONE;
                    else                   w_idx_nxt   = r_idx + 1'b1;
                end
                DONE: begin
                    w_state_nxt = IDLE;
                    w_clear     = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
            if (w_state_nxt != r_state) w_idx_nxt = '0;
        end
    end

    // A stage is enabled exactly when its decoded mode is not HOLD.
    always_comb begin
        w_old_mode = w_dir ? LEFT : RIGHT;
        w_new_mode = w_dir ? RIGHT : LEFT;
        w_mode     = HOLD;
        w_stage_en = '0;
        w_buf_mode = '0;
        w_we       = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_mode = HOLD;
            case (r_state)
                FILL:  if (IDX_W'(k) <= r_idx) w_mode = RIGHT;
                RUN:   w_mode = w_old_mode;
                TURN: begin
                    if (IDX_W'(k + 1) == r_idx)     w_mode = DOWN;
                    else if (IDX_W'(k + 1) < r_idx) w_mode = w_new_mode;
                    else if (IDX_W'(k) > r_idx)     w_mode = w_old_mode;
                end
                DRAIN: if (IDX_W'(k) > r_idx) w_mode = w_old_mode;
                default: w_mode = HOLD;
            endcase
            w_stage_en[k]         = (w_mode != HOLD);
            w_buf_mode[2*k +: 2]  = w_mode;
        end
        case (r_state)
            RUN, DRAIN: w_we = 1'b1;
            TURN:       w_we = (r_idx != TURN_END);
            default:    w_we = 1'b0;
        endcase
        if (w_stall) begin
            w_stage_en = '0;
            w_buf_mode = '0;
            w_we       = 1'b0;
        end
    end

    assign ctrl_bus.stage_en     = w_stage_en;
    assign ctrl_bus.buf_mode     = w_buf_mode;
    assign ctrl_bus.write_enable = w_we;
    assign ctrl_bus.dir          = w_dir;
    assign ctrl_bus.col          = w_col;
    assign ctrl_bus.row          = w_row;
    assign ctrl_bus.busy         = (r_state != IDLE);
    assign ctrl_bus.done         = (r_state == DONE) && !ctrl_bus.stall;

endmodule

// File: tb/tb_scan_pipeline_controller.sv
// Directed bench for scan_pipeline_controller with a 4-stage, 8x3 frame.
module tb_scan_pipeline_controller;

    localparam int NS = 4;
    localparam int NC = 8;
    localparam int NR = 3;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_err;
    int   len;
    int   nwe;
    int   ndone;

    scan_pipeline_controller_if #(.NUM_STAGES(NS), .COLS(NC), .ROWS(NR)) bus ();

    scan_pipeline_controller #(
        .NUM_STAGES (NS),
        .COLS       (NC),
        .ROWS       (NR)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .ctrl_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered on the first RUN cycle; c follows the unstalled schedule.
    task automatic run_frame(input string pfx, input int stall_c,
                             output int flen, output int fwe, output int fdone);
        int c;
        int tot;
        c = 1; tot = 0; flen = 0; fwe = 0; fdone = 0;
        while (bus.busy && tot < 200) begin
            if (c == stall_c) begin
                bus.stall = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk_eq({pfx, "_stall_outs"},
                           {bus.done, bus.write_enable, bus.stage_en, bus.buf_mode}, 0);
                    chk_eq({pfx, "_stall_busy"}, bus.busy, 1);
                    tick();
                    tot++;
                end
                bus.stall = 1'b0;
                #1;
            end
            tot++;
            if (bus.write_enable) fwe++;
            if (bus.done) begin
                fdone++;
                flen = tot;
            end
            case (c)
                1: begin
                    chk_eq({pfx, "_run1_en"},   bus.stage_en, 4'hF);
                    chk_eq({pfx, "_run1_mode"}, bus.buf_mode, 8'h55);
                    chk_eq({pfx, "_run1_we"},   bus.write_enable, 1);
                    chk_eq({pfx, "_run1_col"},  bus.col, 0);
                end
                8:  chk_eq({pfx, "_row0_endcol"}, bus.col, 7);
                9: begin
                    chk_eq({pfx, "_turn0_en"},   bus.stage_en, 4'hE);
                    chk_eq({pfx, "_turn0_mode"}, bus.buf_mode, 8'h54);
                    chk_eq({pfx, "_turn0_we"},   bus.write_enable, 1);
                end
                10: begin
                    chk_eq({pfx, "_turn1_en"},   bus.stage_en, 4'hD);
                    chk_eq({pfx, "_turn1_mode"}, bus.buf_mode, 8'h53);
                end
                11: begin
                    chk_eq({pfx, "_turn2_en"},   bus.stage_en, 4'hB);
                    chk_eq({pfx, "_turn2_mode"}, bus.buf_mode, 8'h4E);
                    chk_eq({pfx, "_turn2_we"},   bus.write_enable, 1);
                end
                12: begin
                    chk_eq({pfx, "_turn3_en"},   bus.stage_en, 4'h7);
                    chk_eq({pfx, "_turn3_mode"}, bus.buf_mode, 8'h3A);
                end
                13: begin
                    chk_eq({pfx, "_turn4_en"},   bus.stage_en, 4'hF);
                    chk_eq({pfx, "_turn4_mode"}, bus.buf_mode, 8'hEA);
                    chk_eq({pfx, "_turn4_we"},   bus.write_enable, 0);
                end
                14: begin
                    chk_eq({pfx, "_row1_dir"},  bus.dir, 1);
                    chk_eq({pfx, "_row1_row"},  bus.row, 1);
                    chk_eq({pfx, "_row1_col"},  bus.col, 7);
                    chk_eq({pfx, "_row1_mode"}, bus.buf_mode, 8'hAA);
                end
                21: chk_eq({pfx, "_row1_endcol"}, bus.col, 0);
                22: begin
                    chk_eq({pfx, "_turnb0_en"},   bus.stage_en, 4'hE);
                    chk_eq({pfx, "_turnb0_mode"}, bus.buf_mode, 8'hA8);
                end
                27: begin
                    chk_eq({pfx, "_row2_dir"}, bus.dir, 0);
                    chk_eq({pfx, "_row2_row"}, bus.row, 2);
                    chk_eq({pfx, "_row2_col"}, bus.col, 0);
                end
                35: begin
                    chk_eq({pfx, "_drain0_en"},   bus.stage_en, 4'hE);
                    chk_eq({pfx, "_drain0_mode"}, bus.buf_mode, 8'h54);
                    chk_eq({pfx, "_drain0_we"},   bus.write_enable, 1);
                end
                38: begin
                    chk_eq({pfx, "_drain3_en"},   bus.stage_en, 4'h0);
                    chk_eq({pfx, "_drain3_mode"}, bus.buf_mode, 8'h00);
                    chk_eq({pfx, "_drain3_we"},   bus.write_enable, 1);
                end
                39: begin
                    chk_eq({pfx, "_done_pulse"}, bus.done, 1);
                    chk_eq({pfx, "_done_en"},    bus.stage_en, 0);
                    chk_eq({pfx, "_done_we"},    bus.write_enable, 0);
                end
                default: ;
            endcase
            bus.start = (c == 3);
            tick();
            c++;
        end
        bus.start = 1'b0;
        chk_eq({pfx, "_idle_after"}, bus.busy, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_rst = 1'b0;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.fill_done = '0;

        repeat (2) tick();
        chk_eq("reset_outs",
               {bus.stage_en, bus.buf_mode, bus.write_enable, bus.dir, bus.col, bus.row,
                bus.busy, bus.done}, 0);
        n_rst = 1'b1;
        tick();
        chk_eq("idle_busy", bus.busy, 0);

        // Frame 1: staged fill with gaps, a stray fill bit and a start pulse in RUN.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_eq("prep_busy", bus.busy, 1);
        chk_eq("prep_en", bus.stage_en, 0);
        tick();
        bus.fill_done = 4'b0100;
        tick();
        bus.fill_done = '0;
        chk_eq("stray_fill_en", bus.stage_en, 4'h1);
        for (int f = 0; f < NS; f++) begin
            logic [3:0] exp_en [4];
            logic [7:0] exp_md [4];
            exp_en = '{4'h1, 4'h3, 4'h7, 4'hF};
            exp_md = '{8'h01, 8'h05, 8'h15, 8'h55};
            chk_eq($sformatf("fill%0d_en", f), bus.stage_en, exp_en[f]);
            chk_eq($sformatf("fill%0d_mode", f), bus.buf_mode, exp_md[f]);
            chk_eq($sformatf("fill%0d_we", f), bus.write_enable, 0);
            tick();
            tick();
            bus.fill_done = 4'b0001 << f;
            tick();
            bus.fill_done = '0;
        end
        run_frame("f1", 0, len, nwe, ndone);
        chk_eq("f1_len", len, 39);
        chk_eq("f1_we_cycles", nwe, 36);
        chk_eq("f1_done_count", ndone, 1);
        chk_eq("f1_end_dir", bus.dir, 0);
        chk_eq("f1_end_pos", {bus.row, bus.col}, 0);

        // Frame 2: stall held for 5 cycles inside TURN(2).
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.fill_done = 4'hF;
        repeat (4) tick();
        bus.fill_done = '0;
        run_frame("f2", 11, len, nwe, ndone);
        chk_eq("f2_len", len, 44);
        chk_eq("f2_we_cycles", nwe, 36);
        chk_eq("f2_done_count", ndone, 1);

        // Frame 3: asynchronous reset in the middle of the first row.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.fill_done = 4'hF;
        repeat (4) tick();
        bus.fill_done = '0;
        repeat (5) tick();
        chk_eq("pre_rst_col", bus.col, 5);
        n_rst = 1'b0;
        #1;
        chk_eq("mid_rst_outs",
               {bus.stage_en, bus.buf_mode, bus.write_enable, bus.dir, bus.col, bus.row,
                bus.busy, bus.done}, 0);
        tick();
        chk_eq("mid_rst_edge_outs",
               {bus.stage_en, bus.buf_mode, bus.write_enable, bus.dir, bus.col, bus.row,
                bus.busy, bus.done}, 0);
        n_rst = 1'b1;
        tick();
        chk_eq("post_rst_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
